// File: rtl/burst_acc_pkg.sv
// Constants shared with the random-data producer, plus the accumulator state encoding.
package burst_acc_pkg;

   localparam int unsigned RND_DATA_W    = 8;
   localparam int unsigned RND_MAX_VAL   = 5;
   localparam int unsigned RND_BURST_MIN = 3;
   localparam int unsigned RND_BURST_MAX = 5;
   localparam int unsigned RND_GAP_MIN   = 1;
   localparam int unsigned RND_GAP_MAX   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_t;

endpackage

// File: rtl/burst_acc_rec_fifo.sv
// Synchronous record FIFO; the head output holds the last popped word while empty.
module rec_fifo #(
   parameter int unsigned W     = 28,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] last;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         last   <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last   <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   assign dout = empty ? last : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/burst_acc.sv
// Summarises each contiguous val burst into {count, sum, max} and queues the records
// behind a valid/ready handshake.
module burst_acc
   import burst_acc_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned DW      = RND_DATA_W,
   parameter int unsigned SW      = 12,
   parameter int unsigned CW      = 8,
   parameter int unsigned MAX_VAL = RND_MAX_VAL
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          val,
   input  logic [DW-1:0] data,
   input  logic          out_rdy,
   output logic          out_val,
   output logic [CW-1:0] out_cnt,
   output logic [SW-1:0] out_sum,
   output logic [DW-1:0] out_max,
   output logic          busy,
   output logic          ovf,
   output logic          err
);

   localparam int unsigned RW = CW + SW + DW;
   localparam logic [DW-1:0] MAX_D = DW'(MAX_VAL);

   acc_state_t    state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] sum;
   logic [DW-1:0] mx;

   logic [SW:0]   sum_wide;
   logic [SW-1:0] sum_sat;
   logic [CW-1:0] cnt_sat;
   logic [DW-1:0] mx_nxt;
   logic          rec_push;
   logic          rec_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [RW-1:0] fifo_dout;

   always_comb begin
      sum_wide = {1'b0, sum} + (SW+1)'(data);
      sum_sat  = sum_wide[SW] ? '1 : sum_wide[SW-1:0];
      cnt_sat  = (cnt == '1) ? cnt : cnt + 1'b1;
      mx_nxt   = (data > mx) ? data : mx;
   end

   // The first idle sample after a burst closes it; the record is written on that edge.
   assign rec_push = (state == ACC) && !val;
   assign rec_pop  = out_rdy && !fifo_empty;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         cnt   <= '0;
         sum   <= '0;
         mx    <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (val && (data > MAX_D))
            err <= 1'b1;
         if (rec_push && fifo_full && !rec_pop)
            ovf <= 1'b1;
         case (state)
            IDLE: begin
               if (val) begin
                  cnt   <= CW'(1);
                  sum   <= SW'(data);
                  mx    <= data;
                  state <= ACC;
               end
            end
            ACC: begin
               if (val) begin
                  cnt <= cnt_sat;
                  sum <= sum_sat;
                  mx  <= mx_nxt;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   rec_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (rec_push),
      .pop   (rec_pop),
      .din   ({cnt, sum, mx}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_val = !fifo_empty;
   assign busy    = (state == ACC);
   assign {out_cnt, out_sum, out_max} = fifo_dout;

endmodule

// File: tb/tb_burst_acc.sv
// Scoreboard bench for burst_acc: stimulus queues expected records, a monitor checks each pop.
module tb_burst_acc;
   import burst_acc_pkg::*;

   logic        clk;
   logic        rst_b;
   logic        val;
   logic [7:0]  data;
   logic        out_rdy;
   logic        out_val;
   logic [7:0]  out_cnt;
   logic [11:0] out_sum;
   logic [7:0]  out_max;
   logic        busy;
   logic        ovf;
   logic        err;

   typedef struct {
      logic [7:0]  cnt;
      logic [11:0] sum;
      logic [7:0]  mx;
   } rec_t;

   rec_t exp_q[$];
   rec_t e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   pops = 0;
   bit   prod_mode = 0;

   burst_acc #(
      .DEPTH   (4),
      .DW      (8),
      .SW      (12),
      .CW      (8),
      .MAX_VAL (5)
   ) dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .val     (val),
      .data    (data),
      .out_rdy (out_rdy),
      .out_val (out_val),
      .out_cnt (out_cnt),
      .out_sum (out_sum),
      .out_max (out_max),
      .busy    (busy),
      .ovf     (ovf),
      .err     (err)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_rec(input int c, input int s, input int m);
      rec_t r;
      r.cnt = 8'(c);
      r.sum = 12'(s);
      r.mx  = 8'(m);
      exp_q.push_back(r);
   endtask

   // Monitor: a record is consumed at the next rising edge whenever out_val & out_rdy.
   always @(negedge clk) begin
      if (rst_b && out_val && out_rdy) begin
         n_chk++;
         pops++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got cnt=%0d sum=%0d max=%0d expected no record",
                     out_cnt, out_sum, out_max);
         end else begin
            e = exp_q.pop_front();
            if (out_cnt !== e.cnt || out_sum !== e.sum || out_max !== e.mx) begin
               n_fail++;
               $display("FAIL record: got cnt=%0d sum=%0d max=%0d expected cnt=%0d sum=%0d max=%0d",
                        out_cnt, out_sum, out_max, e.cnt, e.sum, e.mx);
            end
         end
         if (prod_mode) begin
            chk("prod_cnt_range", (out_cnt >= 8'(RND_BURST_MIN)) && (out_cnt <= 8'(RND_BURST_MAX)), 1);
            chk("prod_max_range", out_max <= 8'(RND_MAX_VAL), 1);
            chk("prod_sum_bound", 32'(out_sum) <= 32'(RND_MAX_VAL) * 32'(out_cnt), 1);
         end
      end
   end

   task automatic beat(input int d);
      val  = 1'b1;
      data = 8'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      val  = 1'b0;
      data = 8'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      #12;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int exp_pops, input string tag);
      int p0;
      int t;
      p0 = pops;
      t  = 0;
      out_rdy = 1'b1;
      while (out_val && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      out_rdy = 1'b0;
      chk({tag, "_drain_timeout"}, 32'(t < 20), 1);
      chk({tag, "_pops"}, 32'(pops - p0), 32'(exp_pops));
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
   endtask

   initial begin
      int len;
      int gap;
      int d;
      int s;
      int m;
      int cyc;
      int p0;

      rst_b   = 1'b0;
      val     = 1'b0;
      data    = 8'd0;
      out_rdy = 1'b0;

      // Reset then idle
      #20;
      chk("rst_out_val", out_val, 0);
      chk("rst_busy", busy, 0);
      #5;
      rst_b = 1'b1;
      idle(10);
      chk("idle_out_val", out_val, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ovf", ovf, 0);
      chk("idle_err", err, 0);
      chk("idle_out_cnt", out_cnt, 0);
      chk("idle_out_sum", out_sum, 0);
      chk("idle_out_max", out_max, 0);

      // Single burst 2,5,0,3 with held ready
      beat(2);
      chk("single_busy", busy, 1);
      beat(5);
      beat(0);
      beat(3);
      expect_rec(4, 10, 5);
      idle(1);
      chk("single_out_val", out_val, 1);
      chk("single_busy_end", busy, 0);
      repeat (3) begin
         chk("hold_cnt", out_cnt, 4);
         chk("hold_sum", out_sum, 10);
         chk("hold_max", out_max, 5);
         @(posedge clk);
         #1;
      end
      chk("hold_out_val", out_val, 1);
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      out_rdy = 1'b0;
      chk("single_popped", out_val, 0);
      chk("empty_hold_cnt", out_cnt, 4);
      chk("empty_hold_sum", out_sum, 10);
      chk("empty_hold_max", out_max, 5);
      chk("single_q_empty", 32'(exp_q.size()), 0);

      // Overflow: five bursts into a 4-deep FIFO
      for (int b = 0; b < 5; b++) begin
         beat(1);
         beat(1);
         beat(1);
         if (b < 4)
            expect_rec(3, 3, 1);
         idle(1);
         if (b == 3)
            chk("ovf_after_4", ovf, 0);
      end
      chk("ovf_after_5", ovf, 1);
      drain(4, "ovf");
      chk("ovf_sticky", ovf, 1);

      // Full FIFO with pop on the same edge as the 5th push
      do_reset();
      chk("reset_clears_ovf", ovf, 0);
      for (int k = 1; k <= 4; k++) begin
         beat(k);
         beat(k);
         beat(k);
         expect_rec(3, 3 * k, k);
         idle(1);
      end
      beat(5);
      beat(5);
      beat(5);
      expect_rec(3, 15, 5);
      p0      = pops;
      val     = 1'b0;
      data    = 8'd0;
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      out_rdy = 1'b0;
      chk("simul_ovf", ovf, 0);
      chk("simul_one_pop", 32'(pops - p0), 1);
      chk("simul_out_val", out_val, 1);
      drain(4, "simul");

      // Range error
      do_reset();
      beat(1);
      chk("err_before", err, 0);
      beat(7);
      chk("err_set", err, 1);
      beat(2);
      expect_rec(3, 10, 7);
      idle(1);
      drain(1, "err");
      idle(3);
      chk("err_sticky", err, 1);

      // Reset mid-burst
      do_reset();
      beat(4);
      beat(4);
      rst_b = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      #11;
      rst_b = 1'b1;
      val   = 1'b0;
      @(posedge clk);
      #1;
      idle(2);
      chk("midrst_no_rec", out_val, 0);
      chk("midrst_busy_after", busy, 0);
      beat(3);
      beat(3);
      beat(3);
      expect_rec(3, 9, 3);
      idle(1);
      drain(1, "midrst");

      // Producer-like traffic for about 100 cycles
      do_reset();
      prod_mode = 1;
      out_rdy   = 1'b1;
      cyc       = 0;
      while (cyc < 100) begin
         len = int'($urandom_range(RND_BURST_MAX, RND_BURST_MIN));
         s = 0;
         m = 0;
         for (int i = 0; i < len; i++) begin
            d = int'($urandom_range(RND_MAX_VAL, 0));
            beat(d);
            s += d;
            if (d > m)
               m = d;
         end
         expect_rec(len, s, m);
         gap = int'($urandom_range(RND_GAP_MAX, RND_GAP_MIN));
         idle(gap);
         cyc += len + gap;
      end
      drain(0, "prod");
      prod_mode = 0;
      chk("prod_err", err, 0);
      chk("prod_ovf", ovf, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
